// File: rtl/instr_assembler_if.sv
// ---------------------------------------------------------------------------
// instr_assembler_if
// Instruction-field handshake between a program source (master) and the
// instruction assembler (slave).
//   in_valid          master -> slave  field set below is valid
//   in_ready          slave  -> master assembler can take a field set
//   op_sel            master -> slave  instruction class (0..5 legal)
//   rs, rt, rd        master -> slave  register fields
//   funct             master -> slave  R-type function field
//   imm               master -> slave  16-bit immediate
//   target            master -> slave  26-bit jump target
// ---------------------------------------------------------------------------
interface instr_assembler_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op_sel;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;

    modport master (
        output in_valid, op_sel, rs, rt, rd, funct, imm, target,
        input  in_ready
    );

    modport slave (
        input  in_valid, op_sel, rs, rt, rd, funct, imm, target,
        output in_ready
    );
endinterface

// File: rtl/instr_assembler.sv
// ---------------------------------------------------------------------------
// instr_assembler
// Packs symbolic instruction fields into 32-bit MIPS words (lw, sw, R-type,
// addi, beq, j) and writes them to consecutive instruction-memory addresses
// starting at 0. One instruction every two cycles: IDLE accepts, WRITE
// presents the one-cycle strobe and bumps the word count.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   clear        synchronous restart of the load sequence (same effect as rst)
//   inst_if      instruction-field handshake (slave side)
//   imem_we      one-cycle instruction-memory write strobe
//   imem_addr    word address of the write
//   imem_wdata   encoded instruction word
//   count        words written since reset/clear, saturates at DEPTH
//   full         count == DEPTH; no further accepts until rst/clear
//   err_illegal  sticky: an illegal op_sel was accepted
//
// state   | meaning
// --------+----------------------------------------------------
// S_IDLE  | ready for a field set (unless full or in reset)
// S_WRITE | strobe on the bus this cycle; count bumps at its end
// ---------------------------------------------------------------------------
module instr_assembler #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    instr_assembler_if.slave   inst_if,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [31:0]        imem_wdata,
    output logic [ADDR_W:0]    count,
    output logic               full,
    output logic               err_illegal
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                full_q, full_d;
    logic                err_q, err_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;

    logic                in_ready;
    logic                legal;
    logic [31:0]         enc;

    // Not registered: must drop in the same cycle rst is raised.
    assign in_ready         = (state_q == S_IDLE) && !full_q && !rst;
    assign inst_if.in_ready = in_ready;

    always_comb begin
        enc   = '0;
        legal = 1'b1;
        case (inst_if.op_sel)
            3'd0:    enc = {6'b100011, inst_if.rs, inst_if.rt, inst_if.imm};
            3'd1:    enc = {6'b101011, inst_if.rs, inst_if.rt, inst_if.imm};
            3'd2:    enc = {6'b000000, inst_if.rs, inst_if.rt, inst_if.rd,
                            5'b00000, inst_if.funct};
            3'd3:    enc = {6'b001000, inst_if.rs, inst_if.rt, inst_if.imm};
            3'd4:    enc = {6'b000100, inst_if.rs, inst_if.rt, inst_if.imm};
            3'd5:    enc = {6'b000010, inst_if.target};
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (inst_if.in_valid && in_ready) begin
                    if (legal) begin
                        wdata_d = enc;
                        addr_d  = count_q[ADDR_W-1:0];
                        we_d    = 1'b1;
                        state_d = S_WRITE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (count_q != DEPTH_W) begin
                    count_d = count_q + 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // clear wins over an accept; a strobe already on the bus this cycle
        // still reaches the memory because imem_we is registered.
        if (clear) begin
            state_d = S_IDLE;
            count_d = '0;
            err_d   = 1'b0;
            we_d    = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
        end

        full_d = (count_d == DEPTH_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            full_q  <= full_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign count       = count_q;
    assign full        = full_q;
    assign err_illegal = err_q;

endmodule

// File: tb/tb_instr_assembler.sv
module tb_instr_assembler;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk;
    logic              rst;
    logic              clear;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err_illegal;

    instr_assembler_if inst_if ();

    instr_assembler #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .inst_if     (inst_if),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .count       (count),
        .full        (full),
        .err_illegal (err_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_cnt = 0;
    logic [33:0] exp_q[$];
    int strobe_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            strobe_cyc.push_back(cyc);
            chk("ready_low_in_write", {31'b0, inst_if.in_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe_addr", {30'b0, imem_addr}, 32'hFFFF_FFFF);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                chk("strobe_addr", {30'b0, imem_addr}, {30'b0, e[33:32]});
                chk("strobe_data", imem_wdata, e[31:0]);
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [4:0] a_rs, input logic [4:0] a_rt,
                        input logic [4:0] a_rd, input logic [5:0] f, input logic [15:0] im,
                        input logic [25:0] tg, input logic [31:0] exp, input bit hold);
        int n;
        @(negedge clk);
        inst_if.op_sel = op; inst_if.rs = a_rs; inst_if.rt = a_rt; inst_if.rd = a_rd;
        inst_if.funct = f; inst_if.imm = im; inst_if.target = tg; inst_if.in_valid = 1'b1;
        n = 0;
        while (inst_if.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (inst_if.in_ready !== 1'b1) begin
            chk("accept_timeout", {31'b0, inst_if.in_ready}, 32'd1);
        end else if (op <= 3'd5) begin
            exp_q.push_back({2'(exp_cnt), exp});
            exp_cnt++;
        end
        @(posedge clk);
        #1;
        if (!hold) inst_if.in_valid = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        inst_if.in_valid = 1'b0;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0;
        inst_if.in_valid = 1'b0; inst_if.op_sel = '0; inst_if.rs = '0; inst_if.rt = '0;
        inst_if.rd = '0; inst_if.funct = '0; inst_if.imm = '0; inst_if.target = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, inst_if.in_ready}, 32'd0);
        chk("rst_we", {31'b0, imem_we}, 32'd0);
        chk("rst_count", {29'b0, count}, 32'd0);
        chk("rst_full_err", {30'b0, full, err_illegal}, 32'd0);
        chk("rst_addr_data", imem_wdata | {30'b0, imem_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {31'b0, inst_if.in_ready}, 32'd1);

        // addi then R-type; unused fields carry junk
        send(3'd3, 5'd1, 5'd2, 5'd31, 6'h3F, 16'h0005, 26'h3FFFFFF, 32'h20220005, 0);
        send(3'd2, 5'd1, 5'd2, 5'd3, 6'h20, 16'hFFFF, 26'h155_5555, 32'h00221820, 0);
        idle(2);
        chk("count_after_two", {29'b0, count}, 32'd2);

        // lw, sw, beq, j fill the 4-word memory
        do_clear();
        chk("count_after_clear", {29'b0, count}, 32'd0);
        send(3'd0, 5'd0, 5'd8, 5'd7, 6'h11, 16'h0004, 26'h0, 32'h8C080004, 0);
        send(3'd1, 5'd29, 5'd31, 5'd0, 6'h00, 16'h0008, 26'h0, 32'hAFBF0008, 0);
        send(3'd4, 5'd1, 5'd2, 5'd9, 6'h00, 16'hFFFF, 26'h0, 32'h1022FFFF, 0);
        send(3'd5, 5'd7, 5'd7, 5'd7, 6'h3F, 16'hAAAA, 26'h0000010, 32'h08000010, 0);
        @(posedge clk);
        #1;
        chk("full_set", {31'b0, full}, 32'd1);
        chk("count_sat", {29'b0, count}, 32'd4);
        chk("ready_when_full", {31'b0, inst_if.in_ready}, 32'd0);
        // 5th word is refused
        @(negedge clk);
        inst_if.op_sel = 3'd3; inst_if.in_valid = 1'b1;
        idle(6);
        chk("count_still_4", {29'b0, count}, 32'd4);
        do_clear();
        chk("full_cleared", {30'b0, full, count == 0}, 32'd1);
        send(3'd4, 5'd3, 5'd4, 5'd0, 6'h00, 16'h0010, 26'h0, 32'h10640010, 0);
        idle(2);

        // back-to-back with in_valid held high
        do_clear();
        strobe_cyc.delete();
        send(3'd3, 5'd0, 5'd1, 5'd0, 6'h00, 16'h0001, 26'h0, 32'h20010001, 1);
        send(3'd3, 5'd0, 5'd2, 5'd0, 6'h00, 16'h0002, 26'h0, 32'h20020002, 1);
        send(3'd5, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h3FFFFFF, 32'h0BFFFFFF, 0);
        idle(2);
        if (strobe_cyc.size() == 3) begin
            chk("b2b_gap1", strobe_cyc[1] - strobe_cyc[0], 32'd2);
            chk("b2b_gap2", strobe_cyc[2] - strobe_cyc[1], 32'd2);
        end else begin
            chk("b2b_strobes", strobe_cyc.size(), 32'd3);
        end
        chk("count_b2b", {29'b0, count}, 32'd3);

        // illegal op_sel
        send(3'd7, 5'd1, 5'd1, 5'd1, 6'h01, 16'h0001, 26'h1, 32'h0, 0);
        chk("err_set", {31'b0, err_illegal}, 32'd1);
        chk("ready_after_illegal", {31'b0, inst_if.in_ready}, 32'd1);
        idle(2);
        chk("count_after_illegal", {29'b0, count}, 32'd3);
        send(3'd6, 5'd1, 5'd1, 5'd1, 6'h01, 16'h0001, 26'h1, 32'h0, 0);
        send(3'd0, 5'd2, 5'd3, 5'd0, 6'h00, 16'h0100, 26'h0, 32'h8C430100, 0);
        idle(2);
        chk("err_sticky", {31'b0, err_illegal}, 32'd1);
        chk("count_after_legal", {29'b0, count}, 32'd4);
        do_clear();
        chk("err_cleared", {31'b0, err_illegal}, 32'd0);

        // rst in the WRITE cycle of the second instruction
        send(3'd3, 5'd5, 5'd6, 5'd0, 6'h00, 16'h1234, 26'h0, 32'h20A61234, 0);
        send(3'd3, 5'd7, 5'd8, 5'd0, 6'h00, 16'h4321, 26'h0, 32'h20E84321, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_we", {31'b0, imem_we}, 32'd0);
        chk("rst_mid_addr_data", imem_wdata | {30'b0, imem_addr}, 32'd0);
        chk("rst_mid_count", {29'b0, count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        send(3'd2, 5'd4, 5'd5, 5'd6, 6'h22, 16'h0, 26'h0, 32'h00853022, 0);
        idle(2);
        chk("count_after_rst", {29'b0, count}, 32'd1);

        // clear during WRITE: strobe completes, next word lands at 0
        send(3'd3, 5'd1, 5'd1, 5'd0, 6'h00, 16'h0007, 26'h0, 32'h20210007, 0);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        exp_cnt = 0;
        chk("clear_mid_count", {29'b0, count}, 32'd0);
        send(3'd3, 5'd2, 5'd2, 5'd0, 6'h00, 16'h0009, 26'h0, 32'h20420009, 0);
        idle(3);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/instr_assembler.md
# instr_assembler

Sequential instruction encoder that loads the single-cycle processor's instruction memory. It is the producer side of the main control decoder. It accepts symbolic instruction fields over a valid/ready handshake and packs them into 32-bit MIPS words using the opcodes the decoder recognises (lw, sw, R-type, addi, beq, j). It then writes each word to consecutive instruction-memory addresses from 0 upward. It is used by the test infrastructure and by the boot loader to build programs without hand-assembled hex.

## Interface
Parameters:
- DEPTH, 64: number of instruction-memory words; programs longer than this are refused.
- ADDR_W, 6: width of imem_addr; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous restart of the load sequence; same state effect as rst.
- in_valid  input  1  fields on the inputs below are valid.
- in_ready  output  1  block can accept a field set this cycle.
- op_sel  input  3  instruction class: 0 lw, 1 sw, 2 R-type, 3 addi, 4 beq, 5 j; 6 and 7 are illegal.
- rs, rt, rd  input  5 each  register fields.
- funct  input  6  R-type function field.
- imm  input  16  immediate field for lw/sw/addi/beq.
- target  input  26  jump target field for j.
- imem_we  output  1  one-cycle write strobe to instruction memory.
- imem_addr  output  ADDR_W  word address of the write.
- imem_wdata  output  32  encoded instruction.
- count  output  ADDR_W+1  number of words written since reset/clear.
- full  output  1  count == DEPTH.
- err_illegal  output  1  sticky; an illegal op_sel was accepted.

## Operation
- FSM states:
  - IDLE: in_ready = !full && !rst.
  - WRITE: in_ready = 0.
- Accept: an accept occurs on a rising edge with in_valid && in_ready in IDLE.
  - Legal op_sel: latch the encoded word into imem_wdata, set imem_addr = count[ADDR_W-1:0], set imem_we = 1, go to WRITE.
  - Illegal op_sel: set err_illegal = 1, stay in IDLE, no write, count unchanged.
- WRITE lasts exactly one cycle: imem_we drops to 0, count increments, return to IDLE.
- Encoding, MSB to LSB:
  - lw: 100011, rs, rt, imm
  - sw: 101011, rs, rt, imm
  - R-type: 000000, rs, rt, rd, 00000 (shamt), funct
  - addi: 001000, rs, rt, imm
  - beq: 000100, rs, rt, imm
  - j: 000010, target
- Fields not used by a class are ignored.
- full: asserted when count reaches DEPTH. in_ready then stays 0 until rst or clear; in_valid is ignored.
- count saturates at DEPTH and never wraps.
- rst or clear: state = IDLE, count = 0, full = 0, err_illegal = 0, imem_we = 0, imem_addr = 0, imem_wdata = 0.
  - rst has priority over clear; clear has priority over an accept in the same cycle.
- clear asserted during WRITE: the strobe already on the bus that cycle completes at the memory, but count still returns to 0 and the next word overwrites address 0.

## Timing
- All outputs are registered except in_ready, which is combinational from state, full and rst.
- Latency: an accept on edge N makes imem_we = 1 with address/data during cycle N to N+1. The memory captures the word on edge N+1.
- count and full update on edge N+1.
- Throughput: one instruction per 2 cycles. With in_valid held high, strobes occur every other cycle.
- imem_addr and imem_wdata hold their last values while imem_we = 0.
- Reset values: in_ready 0 while rst is high, 1 on the first cycle after rst falls. All other outputs are 0.

## Test plan
- After reset, accept addi (rs=1, rt=2, imm=0x0005), then R-type (rs=1, rt=2, rd=3, funct=0x20) -> writes 0x20220005 @0 and 0x00221820 @1; count=2.
- Accept lw (rs=0, rt=8, imm=4), sw (rs=29, rt=31, imm=8), beq (rs=1, rt=2, imm=0xFFFF), j (target=0x0000010) -> data 0x8C080004, 0xAFBF0008, 0x1022FFFF, 0x08000010 at consecutive addresses.
- Hold in_valid high with 3 instructions -> imem_we pulses on alternate cycles at addresses 0, 1, 2; in_ready low in each WRITE cycle.
- DEPTH=4: write 4 words, then present a 5th -> full=1, count=4, in_ready=0, no 5th strobe; clear -> full=0, count=0; the next accept writes @0.
- Accept op_sel=7 -> err_illegal=1, no imem_we, count unchanged, in_ready stays 1. A following legal accept writes normally and err_illegal stays 1 until clear.
- Assert rst in the WRITE cycle of the second instruction -> all outputs 0 on the next cycle, count=0; after release the first accept writes @0.
